// File: rtl/ita_package.sv
// Shared ITA types and constants used by the activation sequencer.
package ita_package;

  localparam int unsigned N                    = 16;
  localparam int unsigned WI                   = 8;
  localparam int unsigned GELU_CONSTANTS_WIDTH = 16;
  localparam int unsigned EMS                  = 8;

  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    GELU     = 2'd1,
    RELU     = 2'd2
  } activation_e;

  typedef logic signed [GELU_CONSTANTS_WIDTH-1:0] gelu_const_t;
  typedef logic [EMS-1:0]                         requant_const_t;
  typedef logic signed [WI-1:0]                   requant_t;
  typedef requant_t [N-1:0]                       requant_oup_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } act_ctrl_state_e;

  // Number of register stages inside the activation datapath.
  localparam int unsigned ACT_LATENCY = 2;

endpackage

// File: rtl/activation_ctrl_vpipe.sv
// Valid-bit shadow of the 2-stage activation pipeline; generates the advance
// condition, input ready and both stage enables.
module activation_ctrl_vpipe (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic in_valid_i,
  input  logic out_ready_i,
  output logic in_ready_o,
  output logic calc_en_o,
  output logic calc_en_q_o,
  output logic v2_o
);

  logic v1_q;
  logic v2_q;
  logic adv;

  // Whole pipe moves together: it advances whenever the output slot frees up.
  assign adv         = !v2_q || out_ready_i;
  assign in_ready_o  = run_i && adv;
  assign calc_en_o   = adv && in_valid_i && in_ready_o;
  assign calc_en_q_o = adv && v1_q;
  assign v2_o        = v2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (adv) begin
      v1_q <= calc_en_o;
      v2_q <= v1_q;
    end
  end

endmodule

// File: rtl/activation_ctrl.sv
// Job sequencer for the ITA activation unit. Optional performance counters are
// built when ITA_ACT_CTRL_PERF_EN is defined.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid holds its payload until that edge, ready may toggle freely.
module activation_ctrl
  import ita_package::*;
#(
  parameter int unsigned N_PE      = N,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  activation_e               cfg_activation_i,
  input  gelu_const_t               cfg_one_i,
  input  gelu_const_t               cfg_b_i,
  input  gelu_const_t               cfg_c_i,
  input  requant_const_t            cfg_mult_i,
  input  requant_const_t            cfg_shift_i,
  input  requant_t                  cfg_add_i,
  input  logic [CNT_WIDTH-1:0]      cfg_len_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  requant_t [N_PE-1:0]       in_data_i,
  output requant_t [N_PE-1:0]       act_data_o,
  output activation_e               act_activation_o,
  output gelu_const_t               act_one_o,
  output gelu_const_t               act_b_o,
  output gelu_const_t               act_c_o,
  output requant_const_t            act_mult_o,
  output requant_const_t            act_shift_o,
  output requant_t                  act_add_o,
  output logic                      act_calc_en_o,
  output logic                      act_calc_en_q_o,
  input  requant_t [N_PE-1:0]       act_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output requant_t [N_PE-1:0]       out_data_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               stall_cycles_o,
  output logic [31:0]               bubble_cycles_o,
  output act_ctrl_state_e           state_o
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  act_ctrl_state_e state_q;
  cnt_t            len_q;
  cnt_t            in_cnt_q;
  cnt_t            out_cnt_q;
  logic            cfg_ready_q;
  logic            done_q;
  logic            v2;
  logic            run;
  logic            cfg_fire;
  logic            in_fire;
  logic            out_fire;

  assign run      = (state_q == RUN);
  assign cfg_fire = cfg_valid_i && cfg_ready_q;
  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = v2 && out_ready_i;

  activation_ctrl_vpipe u_vpipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (run),
    .in_valid_i  (in_valid_i),
    .out_ready_i (out_ready_i),
    .in_ready_o  (in_ready_o),
    .calc_en_o   (act_calc_en_o),
    .calc_en_q_o (act_calc_en_q_o),
    .v2_o        (v2)
  );

  assign act_data_o  = in_data_i;
  assign out_data_o  = act_data_i;
  assign out_valid_o = v2;
  assign out_last_o  = v2 && (out_cnt_q == len_q - cnt_t'(1));
  assign cfg_ready_o = cfg_ready_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign state_o     = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cfg_ready_q      <= 1'b0;
      done_q           <= 1'b0;
      len_q            <= '0;
      in_cnt_q         <= '0;
      out_cnt_q        <= '0;
      act_activation_o <= IDENTITY;
      act_one_o        <= '0;
      act_b_o          <= '0;
      act_c_o          <= '0;
      act_mult_o       <= '0;
      act_shift_o      <= '0;
      act_add_o        <= '0;
    end else begin
      done_q <= 1'b0;
      if (in_fire)  in_cnt_q  <= in_cnt_q + cnt_t'(1);
      if (out_fire) out_cnt_q <= out_cnt_q + cnt_t'(1);
      unique case (state_q)
        IDLE: begin
          cfg_ready_q <= 1'b1;
          if (cfg_fire) begin
            act_activation_o <= cfg_activation_i;
            act_one_o        <= cfg_one_i;
            act_b_o          <= cfg_b_i;
            act_c_o          <= cfg_c_i;
            act_mult_o       <= cfg_mult_i;
            act_shift_o      <= cfg_shift_i;
            act_add_o        <= cfg_add_i;
            len_q            <= cfg_len_i;
            in_cnt_q         <= '0;
            out_cnt_q        <= '0;
            // An empty job completes immediately without leaving IDLE.
            if (cfg_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              cfg_ready_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (in_fire && (in_cnt_q == len_q - cnt_t'(1))) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_fire && out_last_o) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ITA_ACT_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (cfg_fire) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (v2 && !out_ready_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (run && in_ready_o && !in_valid_i && (bubble_q != '1)) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cycles_o  = stall_q;
  assign bubble_cycles_o = bubble_q;
`else
  assign stall_cycles_o  = '0;
  assign bubble_cycles_o = '0;
`endif

endmodule

// File: tb/tb_activation_ctrl.sv
// Self-checking bench for activation_ctrl with a stand-in activation datapath.
module tb_activation_ctrl;
  import ita_package::*;

  localparam int W = N * WI + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            cfg_valid_i = 1'b0;
  logic            cfg_ready_o;
  activation_e     cfg_activation_i = IDENTITY;
  gelu_const_t     cfg_one_i = '0, cfg_b_i = '0, cfg_c_i = '0;
  requant_const_t  cfg_mult_i = '0, cfg_shift_i = '0;
  requant_t        cfg_add_i = '0;
  logic [15:0]     cfg_len_i = '0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  requant_oup_t    in_data_i = '0;
  requant_oup_t    act_data_o;
  activation_e     act_activation_o;
  gelu_const_t     act_one_o, act_b_o, act_c_o;
  requant_const_t  act_mult_o, act_shift_o;
  requant_t        act_add_o;
  logic            act_calc_en_o, act_calc_en_q_o;
  requant_oup_t    act_data_i;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  requant_oup_t    out_data_o;
  logic            out_last_o, busy_o, done_o;
  logic [31:0]     stall_cycles_o, bubble_cycles_o;
  act_ctrl_state_e state_o;

  activation_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_activation_i(cfg_activation_i), .cfg_one_i(cfg_one_i), .cfg_b_i(cfg_b_i),
    .cfg_c_i(cfg_c_i), .cfg_mult_i(cfg_mult_i), .cfg_shift_i(cfg_shift_i),
    .cfg_add_i(cfg_add_i), .cfg_len_i(cfg_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .act_data_o(act_data_o), .act_activation_o(act_activation_o), .act_one_o(act_one_o),
    .act_b_o(act_b_o), .act_c_o(act_c_o), .act_mult_o(act_mult_o),
    .act_shift_o(act_shift_o), .act_add_o(act_add_o),
    .act_calc_en_o(act_calc_en_o), .act_calc_en_q_o(act_calc_en_q_o),
    .act_data_i(act_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o),
    .stall_cycles_o(stall_cycles_o), .bubble_cycles_o(bubble_cycles_o), .state_o(state_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // ---------------- stand-in activation datapath ----------------
  // GELU is replaced by "add low byte of one" so results are easy to predict.
  function automatic requant_oup_t act_fn(input activation_e m, input gelu_const_t one,
                                          input requant_oup_t x);
    requant_oup_t r;
    requant_t     e;
    for (int i = 0; i < N; i++) begin
      e = x[i];
      case (m)
        RELU:    r[i] = (e < 0) ? requant_t'(0) : e;
        GELU:    r[i] = requant_t'(e + requant_t'(one[7:0]));
        default: r[i] = e;
      endcase
    end
    return r;
  endfunction

  requant_oup_t s1_q, s2_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (act_calc_en_o)   s1_q <= act_fn(act_activation_o, act_one_o, act_data_o);
      if (act_calc_en_q_o) s2_q <= s1_q;
    end
  end
  assign act_data_i = s2_q;

  // ---------------- output ready driver ----------------
  logic rand_rdy = 1'b0;
  logic force_rdy = 1'b1;
  always @(posedge clk_i) begin
    #2;
    out_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0]   exp_q[$];
  activation_e    cur_mode = IDENTITY;
  gelu_const_t    cur_one = '0, cur_b = '0, cur_c = '0;
  requant_const_t cur_mult = '0, cur_shift = '0;
  requant_t       cur_add = '0;
  int             job_len = 0;
  int             sent = 0;
  int             n_out = 0;
  int             first_out_cyc = -1;
  int             accept_cyc = -1;
  logic           done_arm = 1'b0;
  requant_oup_t   last_out = '0;

  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (rst_i) begin
      done_arm = 1'b0;
    end else begin
      check("done_o", done_o, done_arm);
      done_arm = 1'b0;
      check("act_data_o", act_data_o, in_data_i);
      if (busy_o)
        check("act_cfg", {act_activation_o, act_one_o, act_b_o, act_c_o, act_mult_o, act_shift_o, act_add_o},
              {cur_mode, cur_one, cur_b, cur_c, cur_mult, cur_shift, cur_add});
      if (out_valid_o && first_out_cyc < 0) first_out_cyc = cyc;
      if (cfg_valid_i && cfg_ready_o && cfg_len_i == 16'd0) done_arm = 1'b1;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got %0h expected none", out_data_o);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data_o, e[W-2:0]);
          check("out_last", out_last_o, e[W-1]);
          done_arm = e[W-1];
          last_out = out_data_o;
          n_out++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("cfg_ready_after_reset", cfg_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cfg(input activation_e m, input gelu_const_t one, input gelu_const_t b,
                          input gelu_const_t c, input requant_const_t mult,
                          input requant_const_t shift, input requant_t add, input int len);
    bit ok = 0;
    cfg_valid_i = 1'b1; cfg_activation_i = m; cfg_one_i = one; cfg_b_i = b; cfg_c_i = c;
    cfg_mult_i = mult; cfg_shift_i = shift; cfg_add_i = add; cfg_len_i = 16'(len);
    cur_mode = m; cur_one = one; cur_b = b; cur_c = c; cur_mult = mult; cur_shift = shift; cur_add = add;
    job_len = len; sent = 0; n_out = 0; first_out_cyc = -1; accept_cyc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_i);
      if (cfg_ready_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("cfg_handshake");
    @(posedge clk_i);
    #1 cfg_valid_i = 1'b0;
  endtask

  task automatic send_vec(input requant_oup_t d);
    bit ok = 0;
    in_valid_i = 1'b1;
    in_data_i = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_i);
      if (in_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      fail_now("in_handshake");
      in_valid_i = 1'b0;
      return;
    end
    if (accept_cyc < 0) accept_cyc = cyc;
    exp_q.push_back({(sent == job_len - 1), act_fn(cur_mode, cur_one, d)});
    sent++;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int exp_n);
    bit ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !busy_o && !out_valid_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("drain");
    check("out_count", n_out, exp_n);
    @(posedge clk_i);
    #1;
  endtask

  function automatic requant_oup_t make_vec(input int base);
    requant_oup_t r;
    for (int i = 0; i < N; i++) r[i] = requant_t'(base + i);
    return r;
  endfunction

  function automatic requant_oup_t rand_vec();
    requant_oup_t r;
    for (int i = 0; i < N; i++) r[i] = requant_t'($urandom_range(0, 255));
    return r;
  endfunction

  typedef struct {
    activation_e mode;
    gelu_const_t one;
    int          base;
    int          exp0;
    int          exp15;
  } vec_rec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_rec_t     tbl[7];
    requant_oup_t held;
    requant_oup_t v[6];
    gelu_const_t  g_one, g_b, g_c;

    tbl[0] = '{IDENTITY, 16'sd0,      5,    5,   20};
    tbl[1] = '{RELU,     16'sd0,    -10,    0,    5};
    tbl[2] = '{RELU,     16'sd0,      3,    3,   18};
    tbl[3] = '{GELU,     16'sd7,     -3,    4,   19};
    tbl[4] = '{IDENTITY, 16'sd0,   -128, -128, -113};
    tbl[5] = '{RELU,     16'sd0,   -128,    0,    0};
    tbl[6] = '{GELU,     16'sh0105, 120,  125, -116};

    // Reset values
    #1;
    @(negedge clk_i);
    check("rst_outputs", {out_valid_o, in_ready_o, busy_o, done_o, cfg_ready_o, act_calc_en_o,
                          act_calc_en_q_o, out_last_o, act_activation_o, act_one_o, act_b_o, act_c_o,
                          act_mult_o, act_shift_o, act_add_o, stall_cycles_o, bubble_cycles_o, state_o}, '0);
    do_reset();

    // IDENTITY len=4, values 1..4 back-to-back
    send_cfg(IDENTITY, '0, '0, '0, '0, '0, '0, 4);
    for (int k = 1; k <= 4; k++) send_vec(make_vec(k));
    wait_drain(4);
    check("latency", first_out_cyc - accept_cyc, 2);
    check("ident_last_vec", last_out, make_vec(4));

    // Single-vector jobs from the table
    for (int k = 0; k < 7; k++) begin
      send_cfg(tbl[k].mode, tbl[k].one, '0, '0, '0, '0, '0, 1);
      send_vec(make_vec(tbl[k].base));
      wait_drain(1);
      check("tbl_lane0", last_out[0], requant_t'(tbl[k].exp0));
      check("tbl_lane15", last_out[N-1], requant_t'(tbl[k].exp15));
    end

    // RELU backpressure with a full pipeline
    for (int k = 0; k < 6; k++) v[k] = rand_vec();
    force_rdy = 1'b0;
    @(posedge clk_i); #1;
    send_cfg(RELU, '0, '0, '0, '0, '0, '0, 6);
    send_vec(v[0]);
    send_vec(v[1]);
    in_valid_i = 1'b1;
    in_data_i = v[2];
    held = act_fn(RELU, '0, v[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_in_ready", in_ready_o, 1'b0);
      check("bp_enables", {act_calc_en_o, act_calc_en_q_o}, 2'b00);
      check("bp_out_valid", out_valid_o, 1'b1);
      check("bp_data", out_data_o, held);
    end
    @(posedge clk_i); #1;
    force_rdy = 1'b1;
    for (int k = 2; k < 6; k++) send_vec(v[k]);
    wait_drain(6);

    // GELU job with a rogue configuration pulse mid-job
    g_one = gelu_const_t'($urandom); g_b = gelu_const_t'($urandom); g_c = gelu_const_t'($urandom);
    send_cfg(GELU, g_one, g_b, g_c, requant_const_t'($urandom), requant_const_t'($urandom),
             requant_t'($urandom), 8);
    for (int k = 0; k < 3; k++) send_vec(rand_vec());
    cfg_valid_i = 1'b1; cfg_activation_i = RELU; cfg_one_i = ~g_one; cfg_b_i = ~g_b;
    cfg_c_i = ~g_c; cfg_len_i = 16'd3;
    @(negedge clk_i);
    check("rogue_cfg_ready", cfg_ready_o, 1'b0);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    for (int k = 3; k < 8; k++) send_vec(rand_vec());
    wait_drain(8);

    // len=0 job with input offered
    in_valid_i = 1'b1;
    in_data_i = rand_vec();
    send_cfg(IDENTITY, '0, '0, '0, '0, '0, '0, 0);
    @(negedge clk_i);
    check("len0_done", done_o, 1'b1);
    check("len0_busy", busy_o, 1'b0);
    check("len0_in_ready", in_ready_o, 1'b0);
    check("len0_state", state_o, IDLE);
    @(negedge clk_i);
    check("len0_done_clear", done_o, 1'b0);
    check("len0_in_ready2", in_ready_o, 1'b0);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;

    // Reset mid-job after 2 of 5 accepts
    send_cfg(IDENTITY, '0, '0, '0, '0, '0, '0, 5);
    send_vec(make_vec(10));
    send_vec(make_vec(20));
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("midrst_outputs", {out_valid_o, in_ready_o, busy_o, done_o, cfg_ready_o, act_calc_en_o,
                             act_calc_en_q_o, out_last_o, act_activation_o, act_one_o, state_o,
                             stall_cycles_o, bubble_cycles_o}, '0);
    do_reset();
    send_cfg(RELU, '0, '0, '0, '0, '0, '0, 1);
    send_vec(make_vec(-5));
    wait_drain(1);

    // Randomized jobs with random gaps and random backpressure
    rand_rdy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      int len;
      len = $urandom_range(1, 10);
      send_cfg(activation_e'($urandom_range(0, 2)), gelu_const_t'($urandom), gelu_const_t'($urandom),
               gelu_const_t'($urandom), requant_const_t'($urandom), requant_const_t'($urandom),
               requant_t'($urandom), len);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        send_vec(rand_vec());
      end
      wait_drain(len);
    end
    rand_rdy = 1'b0;
    force_rdy = 1'b1;
    @(posedge clk_i); #1;

`ifdef ITA_ACT_CTRL_PERF_EN
    // 3 bubble cycles, then 5 stall cycles on the last vector
    send_cfg(IDENTITY, '0, '0, '0, '0, '0, '0, 4);
    send_vec(make_vec(1));
    send_vec(make_vec(2));
    repeat (3) begin @(posedge clk_i); #1; end
    send_vec(make_vec(3));
    send_vec(make_vec(4));
    force_rdy = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    force_rdy = 1'b1;
    wait_drain(4);
    check("perf_stall", stall_cycles_o, 32'd5);
    check("perf_bubble", bubble_cycles_o, 32'd3);
    send_cfg(IDENTITY, '0, '0, '0, '0, '0, '0, 1);
    @(negedge clk_i);
    check("perf_clear", {stall_cycles_o, bubble_cycles_o}, 64'd0);
    send_vec(make_vec(7));
    wait_drain(1);
`else
    check("perf_tied_off", {stall_cycles_o, bubble_cycles_o}, 64'd0);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
